// File: rtl/pipe_reg_bank_if.sv
// Handshake bundle for pipe_reg_bank: upstream valid/ready/data,
// downstream valid/ready/data, plus enable, flush and occupancy.
//   master: producer/consumer side (drives en, flush, in_*, out_ready)
//   slave : the register bank (drives in_ready, out_valid, out_data, occupancy)
interface pipe_reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output en,
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  en,
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/pipe_reg_bank.sv
// DEPTH-deep, WIDTH-wide elastic pipeline register bank with bubble
// collapsing, global enable, synchronous flush and registered occupancy.
// Ports: clk, rst (async, active-high), bus (pipe_reg_bank_if.slave).
// NEG_EDGE selects the capturing clock edge (1 = falling, 0 = rising).
module pipe_reg_bank #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               NEG_EDGE  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    pipe_reg_bank_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             in_ready;
    logic             in_fire;
    logic             out_fire;

    // Advance chain, walked from the output side. "room" is whether the
    // slot downstream of stage k will be free at the edge; for the last
    // stage that is simply out_ready.
    always_comb begin
        logic room;
        logic a;
        room = bus.out_ready;
        a    = 1'b0;
        adv  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            a      = bus.en & v[k] & room;
            adv[k] = a;
            room   = ~v[k] | a;
        end
    end

    // rst gates in_ready so nothing is offered as accepted while the
    // bank is held in reset.
    assign in_ready = ~rst & bus.en & ~bus.flush & (~v[0] | adv[0]);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = adv[DEPTH-1] & ~bus.flush;

    always_comb begin
        load    = '0;
        load[0] = in_fire;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_comb begin
        v_nxt = v;
        for (int k = 0; k < DEPTH; k++) begin
            d_nxt[k] = d[k];
        end
        if (bus.flush) begin
            v_nxt = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_nxt[k] = RESET_VAL;
            end
        end else begin
            if (load[0]) begin
                v_nxt[0] = 1'b1;
                d_nxt[0] = bus.in_data;
            end else if (adv[0]) begin
                v_nxt[0] = 1'b0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    v_nxt[k] = 1'b1;
                    d_nxt[k] = d[k-1];
                end else if (adv[k]) begin
                    v_nxt[k] = 1'b0;
                end
            end
        end
    end

    // Occupancy is kept as its own counter rather than a popcount so the
    // output is a clean register; it moves by at most one per edge.
    always_comb begin
        occ_nxt = occ;
        if (bus.flush) begin
            occ_nxt = '0;
        end else begin
            unique case ({in_fire, out_fire})
                2'b10:   occ_nxt = occ + OCC_W'(1);
                2'b01:   occ_nxt = occ - OCC_W'(1);
                default: occ_nxt = occ;
            endcase
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    v   <= '0;
                    occ <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        d[k] <= RESET_VAL;
                    end
                end else begin
                    v   <= v_nxt;
                    occ <= occ_nxt;
                    for (int k = 0; k < DEPTH; k++) begin
                        d[k] <= d_nxt[k];
                    end
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v   <= '0;
                    occ <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        d[k] <= RESET_VAL;
                    end
                end else begin
                    v   <= v_nxt;
                    occ <= occ_nxt;
                    for (int k = 0; k < DEPTH; k++) begin
                        d[k] <= d_nxt[k];
                    end
                end
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.occupancy = occ;
endmodule

// File: doc/pipe_reg_bank.md
# pipe_reg_bank

Parametrised multi-stage pipeline register bank with valid/ready handshake, global enable, flush and bubble collapsing. It generalises the design's single 32-bit enabled register into a DEPTH-deep, WIDTH-wide elastic pipeline. It sits between datapath stages that may stall independently, for example a memory-wait stage feeding writeback. It also reports its occupancy for hazard and stall logic.

## Interface
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 2, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every data stage on reset or flush (WIDTH bits)
- NEG_EDGE, 1, 1 = all state captures on falling clk edge; 0 = rising edge
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- en  in  1  global enable; 0 freezes all state
- flush  in  1  synchronous clear of all stages
- in_valid  in  1  upstream item present
- in_ready  out  1  bank accepts in_data this edge
- in_data  in  WIDTH  upstream item
- out_valid  out  1  last stage holds valid item
- out_ready  in  1  downstream accepts out_data this edge
- out_data  out  WIDTH  last-stage data
- occupancy  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): valid bit v[k] and data d[k].
- Advance terms, evaluated combinationally:
  - adv[DEPTH-1] = en & v[DEPTH-1] & out_ready
  - adv[k] = en & v[k] & (!v[k+1] | adv[k+1])
- in_ready = en & !flush & (!v[0] | adv[0]).
- Input fire: in_fire = in_valid & in_ready.
- Output fire: out_fire = adv[DEPTH-1] & !flush.
- Per stage, when not flushing:
  - load[0] = in_fire; load[k] = adv[k-1] for k>0.
  - If load[k], then d[k] takes the upstream data and v[k] becomes 1.
  - Else if adv[k], then v[k] becomes 0 and d[k] holds.
  - Else v[k] and d[k] hold.
- Bubble collapsing: an invalid stage is filled from upstream even while the output is stalled. With out_ready low, the bank fills until all DEPTH stages are valid.
- Precedence: rst > flush > en=0 > normal operation.
  - flush: all v = 0, all d = RESET_VAL, occupancy = 0. A simultaneous in_valid is not accepted (in_ready = 0). flush acts even when en = 0.
  - en = 0 with no flush: no state change; in_ready = 0; no transfer occurs, whatever out_ready is.
- occupancy equals the popcount of v. It is registered and tracks v exactly. It changes by +1, -1 or 0 per edge except on flush or reset.
- out_data = d[DEPTH-1]. It stays stable while out_valid & !out_ready.

## Timing
- All state updates on the active edge selected by NEG_EDGE.
- Async reset: asserting rst immediately forces all v = 0, d = RESET_VAL, out_valid = 0, out_data = RESET_VAL and occupancy = 0. It also forces in_ready = 0 while rst is high. First acceptance is possible on the first active edge after rst deasserts.
- Reset asserted mid-stream discards all items; no partial state survives.
- Latency: an item accepted at edge N appears on out_valid after edge N+DEPTH-1. It is usable from that edge, with no intervening stalls.
- Throughput: 1 item per cycle sustained when out_ready = 1.
- Full bank (occupancy = DEPTH) with out_ready = 1: in_ready = 1 in the same cycle (simultaneous pop and push), and occupancy stays at DEPTH.
- in_ready has a combinational path from out_ready through the adv chain, DEPTH levels deep. No combinational path exists from in_valid to out_valid.
- DEPTH = 1 degenerates to a single enabled register with handshake, and must still obey every rule above.

## Test plan
- Reset: rst pulsed mid-cycle with DEPTH = 3 and RESET_VAL = 32'hDEAD_BEEF -> out_data = DEAD_BEEF, out_valid = 0, occupancy = 0 immediately, without waiting for a clock edge.
- Streaming: DEPTH = 3, out_ready = 1, inputs 1, 2, 3, ... one per cycle -> out_data = 1 after the 3rd edge, then one value per cycle, occupancy steady at 3.
- Backpressure and collapse: DEPTH = 3, out_ready = 0, push A and B with one idle cycle between them -> the bubble collapses and occupancy = 2. Push C -> occupancy = 3, then in_ready = 0. Raise out_ready -> outputs A, B, C in order, and in_ready = 1 in the same cycle.
- Flush: occupancy = 2, flush = 1 with in_valid = 1 and data 0x55 -> next edge occupancy = 0, out_valid = 0, out_data = RESET_VAL, 0x55 not captured.
- Enable hold: en = 0 for 4 cycles, with in_valid = 1 and out_ready = 1 while full -> in_ready = 0 and no state or occupancy change. Then en = 1 -> transfers resume.
- NEG_EDGE = 1 versus 0: same stimulus -> captures occur only on the falling versus the rising edge respectively.
